buzzer_tone_gen: RTL and testbench
==================================

BUZZER_TONE_GEN -- requirements
Module: buzzer_tone_gen

Interface
REQ-001 SHALL have parameter HALF_C4, default 95556: half-period of C4 (261.63 Hz) in clk_50MHz cycles.
REQ-002 SHALL have parameter HALF_E4, default 75843: half-period of E4 (329.63 Hz).
REQ-003 SHALL have parameter HALF_AB4, default 60197: half-period of Ab4 (415.30 Hz).
REQ-004 SHALL have parameter HALF_C5, default 47778: half-period of C5 (523.25 Hz).
REQ-005 SHALL have parameter SUSTAIN_CYCLES, default 5000000: release tail length (0.1 s); used only with NOTE_SUSTAIN_EN.
REQ-006 SHALL have port clk_50MHz  input  1  single clock, all state on its rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports result_c4, result_e4, result_ab4, result_c5  input  1 each  debounced key levels, active-high, already in clk_50MHz domain.
REQ-009 SHALL have port buzzer  output  1  square-wave drive to piezo.
REQ-010 SHALL have port playing  output  1  high in PLAY or SUSTAIN.
REQ-011 SHALL have port note_idx  output  2  active note: 0=C4, 1=E4, 2=Ab4, 3=C5.

Function
REQ-012 SHALL register all four key inputs once (key_q); no further synchronisation.
REQ-013 SHALL select the requested note from key_q by fixed priority C5 > Ab4 > E4 > C4; any_key = OR of key_q.
REQ-014 SHALL implement FSM states IDLE, PLAY, SUSTAIN, encoded in 2 bits; the unused code SHALL go to IDLE.
REQ-015 IDLE: buzzer=0, playing=0, note_idx=0, half-period counter=0; any_key -> PLAY on the next edge, loading the requested note, buzzer=1, counter=0.
REQ-016 Key-to-first-buzzer-rise latency SHALL be exactly 2 cycles after the input rises.
REQ-017 PLAY: counter SHALL increment each cycle; at counter == HALF[active]-1, buzzer toggles and counter clears.
REQ-018 Note change during PLAY SHALL be applied only at a toggle edge (active note := requested note); note_idx updates on the same edge; no truncated half-periods.
REQ-019 Counter SHALL be 17 bits; each HALF value SHALL be >= 2 and < 2^17.
REQ-020 PLAY with any_key=0 SHALL go to IDLE on the next edge (without NOTE_SUSTAIN_EN) or to SUSTAIN (with it).
REQ-021 Simultaneous release and toggle point: the release SHALL win; the state transition occurs and buzzer follows the target state.

Reset
REQ-022 reset_n=0 SHALL immediately force IDLE, buzzer=0, playing=0, note_idx=0, counter=0, sustain counter=0, key_q=0, regardless of clock.
REQ-023 Deassertion mid-press SHALL be treated as a fresh press (REQ-015/016 latency).

Configuration
REQ-024 Macro NOTE_SUSTAIN_EN SHALL compile in the SUSTAIN state and a 23-bit sustain counter.
REQ-025 With NOTE_SUSTAIN_EN: SUSTAIN continues toggling the last active note for SUSTAIN_CYCLES cycles, then goes to IDLE (buzzer=0).
REQ-026 With NOTE_SUSTAIN_EN: any_key in SUSTAIN returns to PLAY without clearing the counter; the requested note applies at the next toggle; the sustain counter clears.
REQ-027 Without NOTE_SUSTAIN_EN: no SUSTAIN logic exists; the state code is unreachable and decodes to IDLE.

Verification (HALF_C4=8, HALF_E4=6, HALF_AB4=5, HALF_C5=4, SUSTAIN_CYCLES=20)
REQ-028 reset_n=0 with keys active -> buzzer=0, playing=0, note_idx=0 with no clock edge required.
REQ-029 result_c4 held from cycle 0 -> buzzer rises at cycle 2; period 16 cycles, 50% duty; note_idx=0.
REQ-030 result_c4 held, result_c5 asserted mid half-period -> current 8-cycle half completes, then 4-cycle halves; note_idx=3 on the switching edge.
REQ-031 All four keys held -> note_idx=3, period 8 cycles.
REQ-032 Release in PLAY -> without macro, buzzer=0 and playing=0 one cycle after key_q drops; with macro, toggling continues for 20 cycles, then IDLE.
REQ-033 reset_n pulsed low mid-tone, key still held -> outputs 0 immediately; after release of reset, buzzer rises 2 cycles later.

Source files
------------

// File: rtl/buzzer_tone_gen_if.sv
// Key-level inputs and tone outputs of buzzer_tone_gen, bundled for port connection.
// The key driver is the master; the tone generator is the slave.
interface buzzer_tone_gen_if;
  logic       result_c4;
  logic       result_e4;
  logic       result_ab4;
  logic       result_c5;
  logic       buzzer;
  logic       playing;
  logic [1:0] note_idx;

  modport master (
    output result_c4, result_e4, result_ab4, result_c5,
    input  buzzer, playing, note_idx
  );

  modport slave (
    input  result_c4, result_e4, result_ab4, result_c5,
    output buzzer, playing, note_idx
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave generator: highest held key (C5 > Ab4 > E4 > C4) sets the tone.
// Define NOTE_SUSTAIN_EN to compile in a SUSTAIN release tail of SUSTAIN_CYCLES cycles.
module buzzer_tone_gen #(
  parameter int HALF_C4        = 95556,
  parameter int HALF_E4        = 75843,
  parameter int HALF_AB4       = 60197,
  parameter int HALF_C5        = 47778,
  parameter int SUSTAIN_CYCLES = 5000000
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  buzzer_tone_gen_if.slave bus
);

  if (HALF_C4 < 2 || HALF_C4 >= 2**17 || HALF_E4 < 2 || HALF_E4 >= 2**17 ||
      HALF_AB4 < 2 || HALF_AB4 >= 2**17 || HALF_C5 < 2 || HALF_C5 >= 2**17 ||
      SUSTAIN_CYCLES < 1 || SUSTAIN_CYCLES >= 2**23) begin : g_bad_params
    $error("buzzer_tone_gen: HALF_* must lie in [2, 2^17), SUSTAIN_CYCLES in [1, 2^23)");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAY    = 2'b01,
    S_SUSTAIN = 2'b10
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_key_q;
  logic [16:0] r_cnt, w_cnt_nxt;
  logic        r_buzzer, w_buzzer_nxt;
  logic [1:0]  r_note, w_note_nxt;

  logic        w_any;
  logic [1:0]  w_req;
  logic [16:0] w_half;
  logic        w_tc;
  logic [16:0] w_step_cnt;
  logic        w_step_buzzer;
  logic [1:0]  w_step_note;

`ifdef NOTE_SUSTAIN_EN
  localparam logic [22:0] LP_SUS_LAST = 23'(SUSTAIN_CYCLES - 1);
  logic [22:0] r_sus_cnt, w_sus_nxt;
`endif

  assign w_any = |r_key_q;

  always_comb begin
    if (r_key_q[3])      w_req = 2'd3;
    else if (r_key_q[2]) w_req = 2'd2;
    else if (r_key_q[1]) w_req = 2'd1;
    else                 w_req = 2'd0;
  end

  always_comb begin
    case (r_note)
      2'd0:    w_half = 17'(HALF_C4);
      2'd1:    w_half = 17'(HALF_E4);
      2'd2:    w_half = 17'(HALF_AB4);
      default: w_half = 17'(HALF_C5);
    endcase
  end

  // A new note is only adopted at a toggle so no half-period is ever cut short.
  assign w_tc          = (r_cnt == w_half - 17'd1);
  assign w_step_cnt    = w_tc ? 17'd0 : r_cnt + 17'd1;
  assign w_step_buzzer = w_tc ? ~r_buzzer : r_buzzer;
  assign w_step_note   = (w_tc && w_any) ? w_req : r_note;

  always_comb begin
    w_state_nxt  = S_IDLE;
    w_cnt_nxt    = 17'd0;
    w_buzzer_nxt = 1'b0;
    w_note_nxt   = 2'd0;
`ifdef NOTE_SUSTAIN_EN
    w_sus_nxt    = 23'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_PLAY;
          w_note_nxt   = w_req;
          w_buzzer_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_any) begin
          w_state_nxt  = S_PLAY;
          w_cnt_nxt    = w_step_cnt;
          w_buzzer_nxt = w_step_buzzer;
          w_note_nxt   = w_step_note;
        end
`ifdef NOTE_SUSTAIN_EN
        else begin
          w_state_nxt  = S_SUSTAIN;
          w_cnt_nxt    = w_step_cnt;
          w_buzzer_nxt = w_step_buzzer;
          w_note_nxt   = w_step_note;
        end
`endif
      end
`ifdef NOTE_SUSTAIN_EN
      S_SUSTAIN: begin
        if (w_any) begin
          w_state_nxt  = S_PLAY;
          w_cnt_nxt    = w_step_cnt;
          w_buzzer_nxt = w_step_buzzer;
          w_note_nxt   = w_step_note;
        end else if (r_sus_cnt != LP_SUS_LAST) begin
          w_state_nxt  = S_SUSTAIN;
          w_cnt_nxt    = w_step_cnt;
          w_buzzer_nxt = w_step_buzzer;
          w_note_nxt   = w_step_note;
          w_sus_nxt    = r_sus_cnt + 23'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_key_q   <= 4'd0;
      r_cnt     <= 17'd0;
      r_buzzer  <= 1'b0;
      r_note    <= 2'd0;
`ifdef NOTE_SUSTAIN_EN
      r_sus_cnt <= 23'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_key_q   <= {bus.result_c5, bus.result_ab4, bus.result_e4, bus.result_c4};
      r_cnt     <= w_cnt_nxt;
      r_buzzer  <= w_buzzer_nxt;
      r_note    <= w_note_nxt;
`ifdef NOTE_SUSTAIN_EN
      r_sus_cnt <= w_sus_nxt;
`endif
    end
  end

  assign bus.buzzer   = r_buzzer;
  assign bus.playing  = (r_state == S_PLAY) || (r_state == S_SUSTAIN);
  assign bus.note_idx = r_note;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen: directed tone/latency/release/reset cases
// plus randomized key patterns against a countdown-based tone model.
module tb_buzzer_tone_gen;
  localparam int HC4 = 8, HE4 = 6, HAB4 = 5, HC5 = 4, SUS = 20;
`ifdef NOTE_SUSTAIN_EN
  localparam bit SUS_EN = 1'b1;
`else
  localparam bit SUS_EN = 1'b0;
`endif

  logic clk_50MHz = 1'b0;
  logic reset_n   = 1'b1;
  buzzer_tone_gen_if bus ();

  buzzer_tone_gen #(
    .HALF_C4(HC4), .HALF_E4(HE4), .HALF_AB4(HAB4), .HALF_C5(HC5), .SUSTAIN_CYCLES(SUS)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .bus       (bus.slave)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: keys seen one cycle late, tone tracked as cycles left in the half-period.
  int half_of [4] = '{HC4, HE4, HAB4, HC5};
  int m_kq, m_mode, m_active, m_level, m_remain, m_sus_left;

  function automatic int req_of(input int k);
    if (k[3])      return 3;
    else if (k[2]) return 2;
    else if (k[1]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_kq = 0; m_mode = 0; m_active = 0; m_level = 0; m_remain = 0; m_sus_left = 0;
  endtask

  task automatic model_tone(input int kp);
    m_remain--;
    if (m_remain == 0) begin
      m_level = 1 - m_level;
      if (kp != 0) m_active = req_of(kp);
      m_remain = half_of[m_active];
    end
  endtask

  task automatic model_idle();
    m_mode = 0; m_active = 0; m_level = 0;
  endtask

  task automatic model_step();
    int kp;
    if (!reset_n) begin
      model_reset();
      return;
    end
    kp   = m_kq;
    m_kq = int'({bus.result_c5, bus.result_ab4, bus.result_e4, bus.result_c4});
    case (m_mode)
      0: if (kp != 0) begin
        m_mode = 1; m_active = req_of(kp); m_level = 1; m_remain = half_of[m_active];
      end
      1: if (kp != 0) model_tone(kp);
         else if (SUS_EN) begin m_mode = 2; m_sus_left = SUS; model_tone(kp); end
         else model_idle();
      default: if (kp != 0) begin
        m_mode = 1; model_tone(kp);
      end else begin
        m_sus_left--;
        if (m_sus_left == 0) model_idle();
        else model_tone(kp);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    model_step();
    @(negedge clk_50MHz);
    check_eq("buzzer",   32'(bus.buzzer),   32'(m_level));
    check_eq("playing",  32'(bus.playing),  32'(m_mode != 0));
    check_eq("note_idx", 32'(bus.note_idx), 32'(m_active));
  endtask

  task automatic set_keys(input logic [3:0] k);
    bus.result_c4  = k[0];
    bus.result_e4  = k[1];
    bus.result_ab4 = k[2];
    bus.result_c5  = k[3];
  endtask

  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while (bus.buzzer === lvl && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (bus.buzzer !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_reset(input int low_ticks);
    reset_n = 1'b0;
    #1;
    check_eq("rst_buzzer",  32'(bus.buzzer),   0);
    check_eq("rst_playing", 32'(bus.playing),  0);
    check_eq("rst_note",    32'(bus.note_idx), 0);
    model_reset();
    repeat (low_ticks) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n, hi, lo;
    logic [3:0] k;
    set_keys(4'b0000);
    #1 reset_n = 1'b0;
    set_keys(4'b1111);
    #1;
    check_eq("por_buzzer",  32'(bus.buzzer),   0);
    check_eq("por_playing", 32'(bus.playing),  0);
    check_eq("por_note",    32'(bus.note_idx), 0);
    model_reset();
    repeat (3) tick();
    set_keys(4'b0000);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // C4 alone: latency 2, 8/8 duty
    set_keys(4'b0001);
    wait_rise(n);
    check_eq("c4_latency", n, 2);
    check_eq("c4_note", 32'(bus.note_idx), 0);
    count_while(1'b1, hi);
    count_while(1'b0, lo);
    check_eq("c4_high", hi, HC4);
    check_eq("c4_low",  lo, HC4);

    // C5 pressed four cycles into a C4 high half: that half still lasts 8 cycles
    repeat (3) tick();
    set_keys(4'b1001);
    count_while(1'b1, n);
    check_eq("c5_switch_wait", n, HC4 - 3);
    check_eq("c5_switch_note", 32'(bus.note_idx), 3);
    count_while(1'b0, lo);
    count_while(1'b1, hi);
    check_eq("c5_low",  lo, HC5);
    check_eq("c5_high", hi, HC5);

    // All keys: C5 wins
    set_keys(4'b1111);
    repeat (12) tick();
    count_while(1'b1, n);
    count_while(1'b0, n);
    count_while(1'b1, hi);
    count_while(1'b0, lo);
    check_eq("all_note", 32'(bus.note_idx), 3);
    check_eq("all_period", hi + lo, 2 * HC5);

    // Release
    set_keys(4'b0000);
    n = 0;
    while (bus.playing === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq("release_ticks", n, SUS_EN ? 2 + SUS : 2);
    check_eq("release_buzzer", 32'(bus.buzzer), 0);

    // Reset mid-tone with key held: fresh press latency afterwards
    set_keys(4'b0100);
    repeat (7) tick();
    pulse_reset(2);
    wait_rise(n);
    check_eq("rst_relatch", n, 2);

    // Randomized key patterns, occasional resets
    for (int it = 0; it < 300; it++) begin
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) k = 4'b0000;
      set_keys(k);
      if ($urandom_range(0, 39) == 0) pulse_reset(int'($urandom_range(1, 3)));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
